// File: rtl/cpu_pkg.sv
// Shared RV32I definitions for the fetch/decode slice: base opcodes,
// fetch FSM encoding and the NOP word substituted on a fetch timeout.
package cpu_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REQ    = 3'd1,
      S_WAIT   = 3'd2,
      S_DECODE = 3'd3,
      S_HOLD   = 3'd4
   } fetch_state_t;

endpackage

// File: rtl/cpu_fetch_decode_if.sv
// Instruction-memory read port: req/ready request phase, rvalid data phase.
interface cpu_fetch_decode_if #(
   parameter int XLEN = 32
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;
   logic            imem_rvalid;
   logic [31:0]     imem_rdata;

   modport master (
      output imem_req, imem_addr,
      input  imem_ready, imem_rvalid, imem_rdata
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ready, imem_rvalid, imem_rdata
   );
endinterface

// File: rtl/cpu_imm_gen.sv
// Combinational RV32I control-flow classifier and PC-offset generator.
module cpu_imm_gen
   import cpu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     i_instr,
   output logic            o_branch,
   output logic            o_jal,
   output logic            o_jalr,
   output logic            o_illegal,
   output logic [XLEN-1:0] o_offset
);

   logic [6:0] w_op;
   assign w_op = i_instr[6:0];

   always_comb begin
      o_branch  = 1'b0;
      o_jal     = 1'b0;
      o_jalr    = 1'b0;
      o_illegal = 1'b0;
      o_offset  = '0;
      unique case (w_op)
         OP_BRANCH: begin
            o_branch = 1'b1;
            o_offset = {{(XLEN-12){i_instr[31]}}, i_instr[7],
                        i_instr[30:25], i_instr[11:8], 1'b0};
         end
         OP_JAL: begin
            o_jal    = 1'b1;
            o_offset = {{(XLEN-20){i_instr[31]}}, i_instr[19:12],
                        i_instr[20], i_instr[30:21], 1'b0};
         end
         // a JALR opcode with nonzero funct3 is not a jump
         OP_JALR: begin
            if (i_instr[14:12] == 3'b000) begin
               o_jalr   = 1'b1;
               o_offset = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
            end
         end
         OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE,
         OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM: ;
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/cpu_fetch_decode.sv
// Fetch/decode stage feeding the multicycle PC unit.
// Optional rvalid watchdog: define FETCH_TIMEOUT_EN.
module cpu_fetch_decode
   import cpu_pkg::*;
#(
   parameter int XLEN = 32
`ifdef FETCH_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 16
`endif
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            flush,
   input  logic [XLEN-1:0] pc,
   cpu_fetch_decode_if.master imem,
   output logic [31:0]     instr,
   output logic            decode_valid,
   output logic            branch,
   output logic            jal,
   output logic            jalr,
   output logic [XLEN-1:0] offset,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [2:0]      funct3,
   output logic            misaligned,
   output logic            illegal
`ifdef FETCH_TIMEOUT_EN
   , output logic          fetch_timeout
`endif
);

   fetch_state_t    r_state;
   logic [XLEN-1:0] r_addr;
   logic [31:0]     r_instr;
   logic            r_dv, r_mis, r_ill;
   logic            r_br, r_jal, r_jalr;
   logic [XLEN-1:0] r_off;
   logic [4:0]      r_rs1, r_rs2, r_rd;
   logic [2:0]      r_f3;
   logic            w_br, w_jal, w_jalr, w_ill;
   logic [XLEN-1:0] w_off;

`ifdef FETCH_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] r_cnt;
   logic          r_to;
   logic          w_expire;
   assign w_expire      = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign fetch_timeout = r_to;
`endif

   cpu_imm_gen #(.XLEN(XLEN)) u_imm (
      .i_instr   (r_instr),
      .o_branch  (w_br),
      .o_jal     (w_jal),
      .o_jalr    (w_jalr),
      .o_illegal (w_ill),
      .o_offset  (w_off)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_instr <= '0;
         r_dv    <= 1'b0;
         r_mis   <= 1'b0;
         r_ill   <= 1'b0;
         r_br    <= 1'b0;
         r_jal   <= 1'b0;
         r_jalr  <= 1'b0;
         r_off   <= '0;
         r_rs1   <= '0;
         r_rs2   <= '0;
         r_rd    <= '0;
         r_f3    <= '0;
`ifdef FETCH_TIMEOUT_EN
         r_cnt   <= '0;
         r_to    <= 1'b0;
`endif
      end else if (flush) begin
         r_state <= S_IDLE;
         r_dv    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         r_to    <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            S_IDLE, S_HOLD: begin
               if (start) begin
                  r_addr <= pc;
                  r_dv   <= 1'b0;
                  r_mis  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                  r_cnt  <= '0;
                  r_to   <= 1'b0;
`endif
                  // misaligned pc never reaches memory
                  if (pc[1:0] != 2'b00) begin
                     r_state <= S_HOLD;
                     r_dv    <= 1'b1;
                     r_mis   <= 1'b1;
                     r_br    <= 1'b0;
                     r_jal   <= 1'b0;
                     r_jalr  <= 1'b0;
                     r_ill   <= 1'b0;
                     r_off   <= '0;
                  end else begin
                     r_state <= S_REQ;
                  end
               end
            end
            S_REQ: begin
`ifdef FETCH_TIMEOUT_EN
               r_cnt <= r_cnt + 1'b1;
               if (w_expire) begin
                  r_instr <= NOP_INSTR;
                  r_to    <= 1'b1;
                  r_state <= S_DECODE;
               end else
`endif
               if (imem.imem_ready) r_state <= S_WAIT;
            end
            S_WAIT: begin
`ifdef FETCH_TIMEOUT_EN
               r_cnt <= r_cnt + 1'b1;
`endif
               if (imem.imem_rvalid) begin
                  r_instr <= imem.imem_rdata;
                  r_state <= S_DECODE;
               end
`ifdef FETCH_TIMEOUT_EN
               else if (w_expire) begin
                  r_instr <= NOP_INSTR;
                  r_to    <= 1'b1;
                  r_state <= S_DECODE;
               end
`endif
            end
            S_DECODE: begin
               r_br    <= w_br;
               r_jal   <= w_jal;
               r_jalr  <= w_jalr;
               r_ill   <= w_ill;
               r_off   <= w_off;
               r_rs1   <= r_instr[19:15];
               r_rs2   <= r_instr[24:20];
               r_rd    <= r_instr[11:7];
               r_f3    <= r_instr[14:12];
               r_dv    <= 1'b1;
               r_state <= S_HOLD;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign imem.imem_req  = (r_state == S_REQ);
   assign imem.imem_addr = r_addr;
   assign instr          = r_instr;
   assign decode_valid   = r_dv;
   assign branch         = r_br;
   assign jal            = r_jal;
   assign jalr           = r_jalr;
   assign offset         = r_off;
   assign rs1            = r_rs1;
   assign rs2            = r_rs2;
   assign rd             = r_rd;
   assign funct3         = r_f3;
   assign misaligned     = r_mis;
   assign illegal        = r_ill;

endmodule

// File: tb/tb_cpu_fetch_decode.sv
// Scoreboard bench for cpu_fetch_decode (build with FETCH_TIMEOUT_EN for the watchdog case).
module tb_cpu_fetch_decode;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start, flush;
   logic [31:0] pc;
   logic [31:0] instr, offset;
   logic        decode_valid, branch, jal, jalr, misaligned, illegal;
   logic [4:0]  rs1, rs2, rd;
   logic [2:0]  funct3;
`ifdef FETCH_TIMEOUT_EN
   logic        fetch_timeout;
`endif

   cpu_fetch_decode_if #(.XLEN(32)) imem ();

   cpu_fetch_decode #(.XLEN(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .flush        (flush),
      .pc           (pc),
      .imem         (imem),
      .instr        (instr),
      .decode_valid (decode_valid),
      .branch       (branch),
      .jal          (jal),
      .jalr         (jalr),
      .offset       (offset),
      .rs1          (rs1),
      .rs2          (rs2),
      .rd           (rd),
      .funct3       (funct3),
      .misaligned   (misaligned),
      .illegal      (illegal)
`ifdef FETCH_TIMEOUT_EN
      , .fetch_timeout (fetch_timeout)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [31:0] instr;
      logic        br, jl, jr, ill;
      logic [31:0] off;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  f3;
   } exp_t;

   exp_t sb[$];

   task automatic run_fetch(input logic [31:0] a, input exp_t e,
                            input int rdly);
      exp_t g;
      int   lat;
      sb.push_back(e);
      @(negedge clk); pc = a; start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("req", imem.imem_req, 1);
      chk("addr", imem.imem_addr, a);
      chk("dv_drop", decode_valid, 0);
      for (int i = 0; i < rdly; i++) begin
         @(negedge clk);
         chk("req_hold", imem.imem_req, 1);
         chk("addr_hold", imem.imem_addr, a);
      end
      imem.imem_ready = 1'b1;
      @(negedge clk); imem.imem_ready = 1'b0;
      chk("req_off", imem.imem_req, 0);
      imem.imem_rvalid = 1'b1;
      imem.imem_rdata  = e.instr;
      @(negedge clk); imem.imem_rvalid = 1'b0;
      lat = 2 + rdly;
      for (int i = 0; i < 20 && !decode_valid; i++) begin
         @(negedge clk); lat++;
      end
      if (!decode_valid) begin
         chk("dv_wait", 0, 1);
         return;
      end
      chk("latency", lat, 3 + rdly);
      g = sb.pop_front();
      chk("instr", instr, g.instr);
      chk("branch", branch, g.br);
      chk("jal", jal, g.jl);
      chk("jalr", jalr, g.jr);
      chk("illegal", illegal, g.ill);
      chk("offset", offset, g.off);
      chk("rs1", rs1, g.rs1);
      chk("rs2", rs2, g.rs2);
      chk("rd", rd, g.rd);
      chk("funct3", funct3, g.f3);
      chk("misaligned", misaligned, 0);
`ifdef FETCH_TIMEOUT_EN
      chk("fto_clr", fetch_timeout, 0);
`endif
      @(negedge clk);
      chk("dv_stable", decode_valid, 1);
      chk("off_stable", offset, g.off);
   endtask

   logic [31:0] prev;
   int          n;

   initial begin
      reset = 1'b1; start = 1'b0; flush = 1'b0; pc = '0;
      imem.imem_ready = 1'b0; imem.imem_rvalid = 1'b0;
      imem.imem_rdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_dv", decode_valid, 0);
      chk("rst_instr", instr, 0);
      chk("rst_off", offset, 0);
      chk("rst_addr", imem.imem_addr, 0);
      chk("rst_req", imem.imem_req, 0);
      reset = 1'b0;

      run_fetch(32'h100, '{instr:32'h00C0006F, br:0, jl:1, jr:0, ill:0,
                off:32'd12, rs1:0, rs2:12, rd:0, f3:0}, 0);
      run_fetch(32'h104, '{instr:32'hFE208CE3, br:1, jl:0, jr:0, ill:0,
                off:32'hFFFFFFF8, rs1:1, rs2:2, rd:25, f3:0}, 0);
      run_fetch(32'h108, '{instr:32'h010280E7, br:0, jl:0, jr:1, ill:0,
                off:32'd16, rs1:5, rs2:16, rd:1, f3:0}, 4);
      run_fetch(32'h10C, '{instr:32'hFF9FF0EF, br:0, jl:1, jr:0, ill:0,
                off:32'hFFFFFFF8, rs1:31, rs2:25, rd:1, f3:7}, 1);

      // misaligned start from HOLD
      @(negedge clk); pc = 32'h102; start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("mis", misaligned, 1);
      chk("mis_dv", decode_valid, 1);
      chk("mis_br", branch, 0);
      chk("mis_jal", jal, 0);
      chk("mis_off", offset, 0);
      n = 0;
      repeat (3) begin
         @(negedge clk);
         if (imem.imem_req) n++;
      end
      chk("mis_noreq", n, 0);

      run_fetch(32'h110, '{instr:32'hFFFFFFFF, br:0, jl:0, jr:0, ill:1,
                off:32'd0, rs1:31, rs2:31, rd:31, f3:7}, 0);
      run_fetch(32'h114, '{instr:32'h00500093, br:0, jl:0, jr:0, ill:0,
                off:32'd0, rs1:0, rs2:5, rd:1, f3:0}, 0);

      // flush in WAIT, late rvalid discarded
      prev = 32'h00500093;
      @(negedge clk); pc = 32'h200; start = 1'b1;
      @(negedge clk); start = 1'b0; imem.imem_ready = 1'b1;
      @(negedge clk); imem.imem_ready = 1'b0; flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      chk("fl_dv", decode_valid, 0);
      chk("fl_req", imem.imem_req, 0);
      imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h00C0006F;
      @(negedge clk); imem.imem_rvalid = 1'b0;
      chk("fl_instr", instr, prev);
      repeat (2) @(negedge clk);
      chk("fl_dv2", decode_valid, 0);
      chk("fl_instr2", instr, prev);

      // start and flush together: stays IDLE
      @(negedge clk); pc = 32'h300; start = 1'b1; flush = 1'b1;
      @(negedge clk); start = 1'b0; flush = 1'b0;
      chk("sf_req", imem.imem_req, 0);
      chk("sf_addr", imem.imem_addr, 32'h200);
      @(negedge clk);
      chk("sf_req2", imem.imem_req, 0);
      chk("sf_dv", decode_valid, 0);

`ifdef FETCH_TIMEOUT_EN
      @(negedge clk); pc = 32'h400; start = 1'b1;
      @(negedge clk); start = 1'b0; imem.imem_ready = 1'b1;
      @(negedge clk); imem.imem_ready = 1'b0;
      n = 2;
      for (int i = 0; i < 40 && !decode_valid; i++) begin
         @(negedge clk); n++;
      end
      chk("to_lat", n, 18);
      chk("to_flag", fetch_timeout, 1);
      chk("to_instr", instr, NOP_INSTR);
      chk("to_br", branch, 0);
      chk("to_jal", jal, 0);
      chk("to_jalr", jalr, 0);
      chk("to_ill", illegal, 0);
      run_fetch(32'h404, '{instr:32'h00C0006F, br:0, jl:1, jr:0, ill:0,
                off:32'd12, rs1:0, rs2:12, rd:0, f3:0}, 0);
`endif

      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
